// File: rtl/clk_2_crc_engine_pkg.sv
// Shared constants, state encoding and the single-bit LFSR step for the clk_2 CRC engine.
package crc_pkg;

    localparam int MSG_W = 60;

    localparam logic [4:0] POLY5 = 5'h05;
    localparam logic [7:0] POLY8 = 8'h07;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;
    localparam logic SEL_CRC5 = 1'b0;
    localparam logic SEL_CRC8 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One MSB-first shift; a CRC-5 result lives in [4:0] with the upper bits held at zero.
    function automatic logic [7:0] crc_step(input logic [7:0] lfsr, input logic bit_in,
                                            input logic sel);
        logic       fb;
        logic [4:0] r5;
        logic [7:0] r8;
        r8 = 8'h00;
        if (sel == SEL_CRC8) begin
            fb = bit_in ^ lfsr[7];
            r8 = {lfsr[6:0], 1'b0} ^ (fb ? POLY8 : 8'h00);
        end else begin
            fb = bit_in ^ lfsr[4];
            r5 = {lfsr[3:0], 1'b0} ^ (fb ? POLY5 : 5'h00);
            r8 = {3'b000, r5};
        end
        return r8;
    endfunction

endpackage

// File: rtl/clk_2_crc_engine_toggle_pulse_sync.sv
// Receives a toggle-level flag from another clock domain and emits one pulse per level change.
module toggle_pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= toggle_i;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] ^ edge_q;

endmodule

// File: rtl/clk_2_crc_engine.sv
// Bit-serial CRC-5/CRC-8 generate/check engine fed by a toggle-flag handshake from clk1,
// with a one-deep pending buffer for messages that arrive while a job is running.
module clk_2_crc_engine #(
    parameter int MSG_W       = 60,
    parameter int SYNC_STAGES = 2,
    parameter int OUT_W       = 8
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [MSG_W-1:0] clk1_message,
    input  logic             clk1_CRC,
    input  logic             clk1_mode,
    input  logic             clk1_flag,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             drop
);
    import crc_pkg::*;

    localparam int CNT_W = $clog2(MSG_W);

    state_t             state_q;
    logic [MSG_W-1:0]   msg_q;
    logic               mode_q;
    logic               sel_q;
    logic [7:0]         lfsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MSG_W-1:0]   pend_msg_q;
    logic               pend_mode_q;
    logic               pend_sel_q;
    logic               pend_v_q;

    logic               evt;
    logic               load_en;
    logic               wr_pend;
    logic [7:0]         lfsr_d;
    logic [7:0]         result_d;

    toggle_pulse_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk_2),
        .rst_n   (rst_n),
        .toggle_i(clk1_flag),
        .pulse_o (evt)
    );

    // Pending always wins a load, so an event that coincides with it is parked instead.
    always_comb begin
        load_en  = ((state_q == IDLE) || (state_q == DONE)) && (evt || pend_v_q);
        wr_pend  = evt && ((state_q == SHIFT) || ((state_q == DONE) && pend_v_q));
        lfsr_d   = crc_step(lfsr_q, msg_q[MSG_W-1], sel_q);
        result_d = (mode_q == MODE_CHK) ? {7'd0, (lfsr_q == 8'd0)} : lfsr_q;
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            mode_q      <= MODE_GEN;
            sel_q       <= SEL_CRC5;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            pend_msg_q  <= '0;
            pend_mode_q <= 1'b0;
            pend_sel_q  <= 1'b0;
            pend_v_q    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            drop        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            drop      <= evt && pend_v_q;

            case (state_q)
                IDLE: begin
                    if (load_en) state_q <= SHIFT;
                end
                SHIFT: begin
                    lfsr_q <= lfsr_d;
                    msg_q  <= msg_q << 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MSG_W - 1)) state_q <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_data  <= OUT_W'(result_d);
                    state_q   <= load_en ? SHIFT : IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (load_en) begin
                msg_q  <= pend_v_q ? pend_msg_q  : clk1_message;
                mode_q <= pend_v_q ? pend_mode_q : clk1_mode;
                sel_q  <= pend_v_q ? pend_sel_q  : clk1_CRC;
                lfsr_q <= '0;
                cnt_q  <= '0;
            end

            if (wr_pend) begin
                pend_msg_q  <= clk1_message;
                pend_mode_q <= clk1_mode;
                pend_sel_q  <= clk1_CRC;
                pend_v_q    <= 1'b1;
            end else if (load_en && pend_v_q) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_clk_2_crc_engine.sv
// Self-checking bench for clk_2_crc_engine against a polynomial-division reference model.
module tb_clk_2_crc_engine;

    logic        clk_2 = 1'b0;
    logic        rst_n = 1'b0;
    logic [59:0] clk1_message = '0;
    logic        clk1_CRC = 1'b0;
    logic        clk1_mode = 1'b0;
    logic        clk1_flag = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic        drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int          ov_cyc[$];
    logic [7:0]  ov_dat[$];
    logic        ov_busy[$];

    always #5 clk_2 = ~clk_2;

    clk_2_crc_engine #(
        .MSG_W(60),
        .SYNC_STAGES(2),
        .OUT_W(8)
    ) dut (
        .clk_2       (clk_2),
        .rst_n       (rst_n),
        .clk1_message(clk1_message),
        .clk1_CRC    (clk1_CRC),
        .clk1_mode   (clk1_mode),
        .clk1_flag   (clk1_flag),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .drop        (drop)
    );

    // Remainder of M(x)*x^n divided by the full generator polynomial, by long division.
    function automatic logic [7:0] expect_out(input logic [59:0] m, input logic mode,
                                              input logic sel8);
        int          n;
        logic [67:0] v;
        logic [67:0] p;
        logic [7:0]  rem;
        n = sel8 ? 8 : 5;
        p = sel8 ? 68'h107 : 68'h25;
        v = {8'h00, m} << n;
        for (int i = 67; i >= n; i--) begin
            if (v[i]) v = v ^ (p << (i - n));
        end
        rem = v[7:0];
        if (mode) return (rem == 8'd0) ? 8'd1 : 8'd0;
        return rem;
    endfunction

    function automatic logic [59:0] rand_msg();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[59:0];
    endfunction

    task automatic clear_log();
        ov_cyc.delete();
        ov_dat.delete();
        ov_busy.delete();
        drop_cnt = 0;
        cyc = 0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_2);
            cyc++;
            if (out_valid) begin
                ov_cyc.push_back(cyc);
                ov_dat.push_back(out_data);
                ov_busy.push_back(busy);
            end
            if (drop) drop_cnt++;
        end
    endtask

    task automatic send(input logic [59:0] m, input logic mode, input logic sel8);
        clk1_message = m;
        clk1_mode = mode;
        clk1_CRC = sel8;
        clk1_flag = ~clk1_flag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk1_flag = 1'b0;
        step(3);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop); end
        rst_n = 1'b1;
        clear_log();
        step(5);
        checks++; if (ov_cyc.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle: got valids=%0d busy=%b expected 0/0", ov_cyc.size(), busy); end
        $display("test_reset: done");
    endtask

    task automatic test_directed();
        logic [59:0] vm [5] = '{60'h1, 60'h1, 60'h0, 60'h107, 60'h106};
        logic        vmode [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vsel [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  vexp [5] = '{8'h07, 8'h05, 8'h00, 8'h01, 8'h00};
        for (int k = 0; k < 5; k++) begin
            clear_log();
            send(vm[k], vmode[k], vsel[k]);
            step(70);
            checks++;
            if (ov_cyc.size() != 1) begin
                failures++; $display("FAIL directed%0d_count: got %0d expected 1", k, ov_cyc.size());
            end else begin
                checks++; if (ov_dat[0] !== vexp[k]) begin failures++; $display("FAIL directed%0d_data: got %h expected %h", k, ov_dat[0], vexp[k]); end
                checks++; if (ov_cyc[0] != 64) begin failures++; $display("FAIL directed%0d_latency: got %0d expected 64", k, ov_cyc[0]); end
            end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL directed%0d_busy_after: got %b expected 0", k, busy); end
            $display("directed %0d: msg=%h mode=%b crc8=%b data=%h", k, vm[k], vmode[k], vsel[k], vexp[k]);
        end
    endtask

    task automatic test_random();
        logic [59:0] m;
        logic [59:0] d;
        logic        mode, sel8;
        logic [7:0]  exp_v;
        int          n;
        for (int k = 0; k < 16; k++) begin
            mode = 1'($urandom_range(0, 1));
            sel8 = 1'($urandom_range(0, 1));
            m = rand_msg();
            if (mode && $urandom_range(0, 1) == 1) begin
                n = sel8 ? 8 : 5;
                d = m >> n;
                m = (d << n) | 60'(expect_out(d, 1'b0, sel8));
            end
            exp_v = expect_out(m, mode, sel8);
            clear_log();
            send(m, mode, sel8);
            step(66);
            checks++;
            if (ov_cyc.size() != 1) begin
                failures++; $display("FAIL random%0d_count: got %0d expected 1", k, ov_cyc.size());
            end else begin
                checks++; if (ov_dat[0] !== exp_v) begin failures++; $display("FAIL random%0d_data: got %h expected %h", k, ov_dat[0], exp_v); end
            end
            $display("random %0d: msg=%h mode=%b crc8=%b expect=%h", k, m, mode, sel8, exp_v);
        end
    endtask

    task automatic test_overwrite();
        logic [59:0] m1, m2, m3;
        logic [7:0]  e1, e3;
        m1 = rand_msg(); m2 = rand_msg(); m3 = rand_msg();
        e1 = expect_out(m1, 1'b0, 1'b1);
        e3 = expect_out(m3, 1'b0, 1'b0);
        clear_log();
        send(m1, 1'b0, 1'b1);
        step(10);
        send(m2, 1'b1, 1'b1);
        step(10);
        send(m3, 1'b0, 1'b0);
        step(130);
        checks++; if (drop_cnt != 1) begin failures++; $display("FAIL overwrite_drop: got %0d expected 1", drop_cnt); end
        checks++;
        if (ov_cyc.size() != 2) begin
            failures++; $display("FAIL overwrite_count: got %0d expected 2", ov_cyc.size());
        end else begin
            checks++; if (ov_dat[0] !== e1) begin failures++; $display("FAIL overwrite_job1: got %h expected %h", ov_dat[0], e1); end
            checks++; if (ov_dat[1] !== e3) begin failures++; $display("FAIL overwrite_job3: got %h expected %h", ov_dat[1], e3); end
            checks++; if (ov_cyc[1] - ov_cyc[0] != 61) begin failures++; $display("FAIL overwrite_spacing: got %0d expected 61", ov_cyc[1] - ov_cyc[0]); end
        end
        $display("overwrite: job1=%h job3=%h drops=%0d", e1, e3, drop_cnt);
    endtask

    task automatic test_reset_mid_shift();
        logic [59:0] m;
        logic [7:0]  e;
        clear_log();
        send(rand_msg(), 1'b0, 1'b1);
        step(10);
        send(rand_msg(), 1'b0, 1'b0);
        step(23);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        clk1_flag = 1'b0;
        step(1);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset_busy_after: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        step(1);
        rst_n = 1'b1;
        step(140);
        checks++; if (ov_cyc.size() != 0) begin failures++; $display("FAIL midreset_no_valid: got %0d expected 0", ov_cyc.size()); end
        m = rand_msg();
        e = expect_out(m, 1'b0, 1'b1);
        clear_log();
        send(m, 1'b0, 1'b1);
        step(70);
        checks++;
        if (ov_cyc.size() != 1) begin
            failures++; $display("FAIL midreset_fresh_count: got %0d expected 1", ov_cyc.size());
        end else begin
            checks++; if (ov_dat[0] !== e) begin failures++; $display("FAIL midreset_fresh_data: got %h expected %h", ov_dat[0], e); end
        end
        $display("reset_mid_shift: fresh expect=%h", e);
    endtask

    task automatic test_back_to_back();
        logic [59:0] m1, m2;
        logic [7:0]  e1, e2;
        m1 = rand_msg(); m2 = rand_msg();
        e1 = expect_out(m1, 1'b0, 1'b0);
        e2 = expect_out(m2, 1'b0, 1'b1);
        clear_log();
        send(m1, 1'b0, 1'b0);
        step(61);
        send(m2, 1'b0, 1'b1);
        step(140);
        checks++; if (drop_cnt != 0) begin failures++; $display("FAIL b2b_drop: got %0d expected 0", drop_cnt); end
        checks++;
        if (ov_cyc.size() != 2) begin
            failures++; $display("FAIL b2b_count: got %0d expected 2", ov_cyc.size());
        end else begin
            checks++; if (ov_cyc[0] != 64) begin failures++; $display("FAIL b2b_latency: got %0d expected 64", ov_cyc[0]); end
            checks++; if (ov_cyc[1] - ov_cyc[0] != 61) begin failures++; $display("FAIL b2b_spacing: got %0d expected 61", ov_cyc[1] - ov_cyc[0]); end
            checks++; if (ov_busy[0] !== 1'b1) begin failures++; $display("FAIL b2b_no_idle: got busy=%b expected 1", ov_busy[0]); end
            checks++; if (ov_dat[0] !== e1) begin failures++; $display("FAIL b2b_job1: got %h expected %h", ov_dat[0], e1); end
            checks++; if (ov_dat[1] !== e2) begin failures++; $display("FAIL b2b_job2: got %h expected %h", ov_dat[1], e2); end
        end
        $display("back_to_back: job1=%h job2=%h", e1, e2);
    endtask

    initial begin
        @(negedge clk_2);
        test_reset();
        test_directed();
        test_random();
        test_overwrite();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
